// File: rtl/updi_phy_pkg.sv
// Shared constants and types for the UPDI bit-level physical layer.
package updi_phy_pkg;

  // Frame length: start, 8 data, parity, 2 stop (opaque to the PHY).
  localparam int FRAME_W = 12;
  // Receive-buffer address width.
  localparam int ADDR_W  = 7;

  // Level of the serial lines when nothing is being sent.
  localparam logic IDLE_LINE = 1'b1;

  // Link direction state; the line is half-duplex so only one is active.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2
  } state_t;

endpackage

// File: rtl/phy_shift12.sv
// Frame shift register with bit counter, shared by transmit and receive.
// Loading clears the counter; every shift moves the register one place
// towards bit 0, inserting i_sin at the top, and bumps the counter.
module phy_shift12
  import updi_phy_pkg::*;
#(
  parameter int W     = FRAME_W,
  parameter int CNT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [W-1:0]     i_ldata,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [W-1:0]     o_q,
  output logic [CNT_W-1:0] o_cnt
);

  logic [W-1:0]     r_q;
  logic [CNT_W-1:0] r_cnt;

  // Parallel load has priority over shifting; both hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_q   <= i_ldata;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_q   <= {i_sin, r_q[W-1:1]};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_q   = r_q;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/phy_loader.sv
// UPDI bit-level PHY: serialises frames onto pwdata and deserialises frames
// from prdata into an SRAM-style receive buffer write port.
module phy_loader #(
  parameter int FRAME_W = updi_phy_pkg::FRAME_W,
  parameter int ADDR_W  = updi_phy_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ten,
  input  logic               ren,
  input  logic [FRAME_W-1:0] i_data,
  output logic               pwdata,
  input  logic               prdata,
  output logic               tend,
  output logic               rend,
  output logic               csb0,
  output logic               web0,
  output logic [ADDR_W-1:0]  addr0,
  output logic [FRAME_W-1:0] o_data
);

  import updi_phy_pkg::*;

  localparam int CNT_W = $clog2(FRAME_W);
  // Counter value while the last tx bit is on the line.
  localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(FRAME_W - 1);
  // Counter value when the final rx sample is being shifted in.
  localparam logic [CNT_W-1:0] CNT_RX_LAST = CNT_W'(FRAME_W - 2);

  state_t r_state;
  state_t w_state_nxt;

  logic               r_pwdata;
  logic               r_tend;
  logic               r_rend;
  logic               r_csb0;
  logic               r_web0;
  logic [ADDR_W-1:0]  r_addr0;
  logic [ADDR_W-1:0]  r_wptr;
  logic [FRAME_W-1:0] r_odata;

  logic               w_pwdata_nxt;
  logic               w_tend_nxt;
  logic               w_wr_nxt;
  logic               w_load;
  logic [FRAME_W-1:0] w_ldata;
  logic               w_shift;
  logic               w_sin;
  logic [FRAME_W-1:0] w_q;
  logic [CNT_W-1:0]   w_cnt;
  logic [FRAME_W-1:0] w_rx_frame;

  // For tx, bit 0 goes straight to the line register at capture time, so the
  // shifter holds only the remaining bits and its bit 0 is always the next
  // bit to send. For rx, the start bit is loaded at the top and the rest
  // shift in behind it.
  phy_shift12 #(
    .W     (FRAME_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_load),
    .i_ldata (w_ldata),
    .i_shift (w_shift),
    .i_sin   (w_sin),
    .o_q     (w_q),
    .o_cnt   (w_cnt)
  );

  // Frame as it will stand once the current prdata sample is shifted in.
  assign w_rx_frame = {prdata, w_q[FRAME_W-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shifter control and next values of the registered outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_pwdata_nxt = IDLE_LINE;
    w_tend_nxt   = 1'b0;
    w_wr_nxt     = 1'b0;
    w_load       = 1'b0;
    w_ldata      = {IDLE_LINE, i_data[FRAME_W-1:1]};
    w_shift      = 1'b0;
    w_sin        = IDLE_LINE;
    case (r_state)
      IDLE: begin
        if (ten) begin
          // Transmit wins when both directions are requested.
          w_load       = 1'b1;
          w_pwdata_nxt = i_data[0];
          w_state_nxt  = TX;
        end else if (ren && !prdata) begin
          // The low sample is the start bit, i.e. frame bit 0.
          w_load      = 1'b1;
          w_ldata     = {prdata, {(FRAME_W-1){1'b0}}};
          w_state_nxt = RX;
        end
      end
      TX: begin
        if (w_cnt == CNT_TX_LAST) begin
          if (ten) begin
            // Stream the next frame with no idle gap.
            w_load       = 1'b1;
            w_pwdata_nxt = i_data[0];
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_shift      = 1'b1;
          w_pwdata_nxt = w_q[0];
          w_tend_nxt   = (w_cnt == CNT_TX_LAST - CNT_W'(1));
        end
      end
      RX: begin
        w_shift = 1'b1;
        w_sin   = prdata;
        if (w_cnt == CNT_RX_LAST) begin
          w_wr_nxt    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Line and strobe outputs come straight from flops so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwdata <= IDLE_LINE;
      r_tend   <= 1'b0;
      r_rend   <= 1'b0;
      r_csb0   <= 1'b1;
      r_web0   <= 1'b1;
    end else begin
      r_pwdata <= w_pwdata_nxt;
      r_tend   <= w_tend_nxt;
      r_rend   <= w_wr_nxt;
      r_csb0   <= ~w_wr_nxt;
      r_web0   <= ~w_wr_nxt;
    end
  end

  // Receive buffer write: latch frame and address, then advance the pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_odata <= '0;
      r_addr0 <= '0;
      r_wptr  <= '0;
    end else if (w_wr_nxt) begin
      r_odata <= w_rx_frame;
      r_addr0 <= r_wptr;
      r_wptr  <= r_wptr + ADDR_W'(1);
    end
  end

  assign pwdata = r_pwdata;
  assign tend   = r_tend;
  assign rend   = r_rend;
  assign csb0   = r_csb0;
  assign web0   = r_web0;
  assign addr0  = r_addr0;
  assign o_data = r_odata;

endmodule

// File: tb/tb_phy_loader.sv
// Directed bench for phy_loader: reset, tx single/streamed, rx, priority,
// address wrap and mid-frame reset.
module tb_phy_loader;

  logic        clk;
  logic        rst;
  logic        ten;
  logic        ren;
  logic [11:0] i_data;
  logic        pwdata;
  logic        prdata;
  logic        tend;
  logic        rend;
  logic        csb0;
  logic        web0;
  logic [6:0]  addr0;
  logic [11:0] o_data;

  int n_total = 0;
  int n_bad   = 0;

  phy_loader dut (
    .clk    (clk),
    .rst    (rst),
    .ten    (ten),
    .ren    (ren),
    .i_data (i_data),
    .pwdata (pwdata),
    .prdata (prdata),
    .tend   (tend),
    .rend   (rend),
    .csb0   (csb0),
    .web0   (web0),
    .addr0  (addr0),
    .o_data (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame LSB first with ren high, then check the write cycle.
  task automatic rx_frame(input logic [11:0] d, input logic [6:0] a);
    ren = 1'b1;
    for (int k = 0; k < 12; k++) begin
      prdata = d[k];
      tick();
    end
    prdata = 1'b1;
    chk("rx_rend",  32'(rend),   32'd1);
    chk("rx_csb0",  32'(csb0),   32'd0);
    chk("rx_web0",  32'(web0),   32'd0);
    chk("rx_addr0", 32'(addr0),  32'(a));
    chk("rx_odata", 32'(o_data), 32'(d));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pwdata"}, 32'(pwdata), 32'd1);
    chk({tag, "_tend"},   32'(tend),   32'd0);
    chk({tag, "_rend"},   32'(rend),   32'd0);
    chk({tag, "_csb0"},   32'(csb0),   32'd1);
    chk({tag, "_web0"},   32'(web0),   32'd1);
    chk({tag, "_addr0"},  32'(addr0),  32'd0);
    chk({tag, "_odata"},  32'(o_data), 32'd0);
  endtask

  logic [11:0] f1;
  logic [11:0] bb [3];
  int          nr;

  initial begin
    f1    = 12'b110101010100;
    bb[0] = 12'hC55;
    bb[1] = 12'hDAA;
    bb[2] = 12'hF00;

    // Reset held with random inputs
    rst    = 1'b0;
    ten    = 1'b0;
    ren    = 1'b0;
    prdata = 1'b1;
    i_data = '0;
    for (int i = 0; i < 4; i++) begin
      ten    = 1'($urandom);
      ren    = 1'($urandom);
      prdata = 1'($urandom);
      i_data = 12'($urandom);
      tick();
      chk_reset_outs("rst");
    end
    ten    = 1'b0;
    ren    = 1'b0;
    prdata = 1'b1;
    i_data = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("idle_pwdata", 32'(pwdata), 32'd1);

    // Single frame, i_data scrambled after capture
    i_data = f1;
    ten    = 1'b1;
    tick();
    ten    = 1'b0;
    i_data = 12'hFFF;
    for (int k = 0; k < 12; k++) begin
      chk("tx1_bit",  32'(pwdata), 32'(f1[k]));
      chk("tx1_tend", 32'(tend),   32'(k == 11));
      tick();
    end
    chk("tx1_idle", 32'(pwdata), 32'd1);
    chk("tx1_tend_off", 32'(tend), 32'd0);

    // Back-to-back stream of three frames
    tick();
    i_data = bb[0];
    ten    = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 12; k++) begin
        chk("bb_bit",  32'(pwdata), 32'(bb[f][k]));
        chk("bb_tend", 32'(tend),   32'(k == 11));
        if (k == 0) begin
          if (f < 2) i_data = bb[f+1];
          else       ten = 1'b0;
        end
        tick();
      end
    end
    chk("bb_idle", 32'(pwdata), 32'd1);

    // Receive two frames
    tick();
    rx_frame(12'hC54, 7'd0);
    ren = 1'b0;
    tick();
    chk("rx_rend_off", 32'(rend),   32'd0);
    chk("rx_csb0_off", 32'(csb0),   32'd1);
    chk("rx_web0_off", 32'(web0),   32'd1);
    chk("rx_hold_d",   32'(o_data), 32'h0C54);
    chk("rx_hold_a",   32'(addr0),  32'd0);
    chk("rx_pw_idle",  32'(pwdata), 32'd1);
    rx_frame(12'h3A6, 7'd1);
    ren = 1'b0;
    tick();

    // Both enables with prdata low: transmit wins
    i_data = 12'h0FE;
    ten    = 1'b1;
    ren    = 1'b1;
    prdata = 1'b0;
    tick();
    ten    = 1'b0;
    ren    = 1'b0;
    prdata = 1'b1;
    chk("prio_bit0", 32'(pwdata), 32'd0);
    nr = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      nr += int'(rend);
    end
    chk("prio_no_rend", 32'(nr), 32'd0);
    chk("prio_idle",    32'(pwdata), 32'd1);
    chk("prio_addr",    32'(addr0),  32'd1);

    // Fill addresses 2..127, then the next write wraps to 0
    for (int n = 2; n < 128; n++) begin
      rx_frame({7'(n), 5'b10100}, 7'(n));
    end
    rx_frame(12'hABC, 7'd0);
    ren = 1'b0;
    tick();

    // Reset in the middle of a transmit frame
    i_data = f1;
    ten    = 1'b1;
    tick();
    ten = 1'b0;
    repeat (5) tick();
    chk("mid_bit5", 32'(pwdata), 32'(f1[5]));
    rst = 1'b0;
    #1;
    chk("mid_rst_pw",   32'(pwdata), 32'd1);
    chk("mid_rst_tend", 32'(tend),   32'd0);
    chk("mid_rst_addr", 32'(addr0),  32'd0);
    tick();
    rst    = 1'b1;
    ten    = 1'b1;
    i_data = f1;
    tick();
    ten = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("mid_new_bit",  32'(pwdata), 32'(f1[k]));
      chk("mid_new_tend", 32'(tend),   32'(k == 11));
      tick();
    end
    chk("mid_new_idle", 32'(pwdata), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/phy_loader.md
Name: phy_loader

Overview:
- Bit-level physical layer for the single-wire, half-duplex UPDI link.
- Transmit path: serialises a 12-bit frame word from i_data onto pwdata, LSB first, one bit per clock.
- Receive path: deserialises 12-bit frames from prdata and stores each one through an SRAM-style write port (csb0/web0/addr0/o_data).
- Sits between the UPDI link/control layer and the pad/UART wrapper.

Parameters:
- FRAME_W, 12, frame length in bits (start, 8 data, parity, 2 stop; content is opaque to this block).
- ADDR_W, 7, width of the receive-buffer address.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- ten  input  1  transmit enable; level-sensitive request to send i_data.
- ren  input  1  receive enable; arms frame detection on prdata.
- i_data  input  FRAME_W  frame to transmit, bit 0 sent first.
- pwdata  output  1  serial transmit line, idles high.
- prdata  input  1  serial receive line, idles high.
- tend  output  1  one-cycle pulse: last bit of a transmitted frame is on pwdata.
- rend  output  1  one-cycle pulse: received frame valid on o_data and being written.
- csb0  output  1  receive-buffer chip select, active low.
- web0  output  1  receive-buffer write enable, active low.
- addr0  output  ADDR_W  receive-buffer write address.
- o_data  output  FRAME_W  last received frame, doubling as the buffer write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - pwdata=1, tend=0, rend=0, csb0=1, web0=1.
  - addr0=0, o_data=0.
  - FSM to IDLE, bit counters to 0.
- FSM states: IDLE, TX, RX.
- IDLE:
  - ten=1 at a rising edge: capture i_data into the shift register, go to TX. pwdata=i_data[0] from the next cycle.
  - Otherwise, ren=1 and prdata=0 at an edge: the sampled 0 is taken as bit 0 (start bit); go to RX.
  - ten has priority over ren when both are high (half-duplex).
- TX:
  - pwdata shows bit k during the k-th cycle after capture, k=0..11; registered output, no glitches.
  - tend=1 during the cycle bit 11 is on pwdata.
  - At the end of bit 11, if ten=1: capture the new i_data and start the next frame with no idle gap, so frames stream back-to-back every 12 cycles. If ten=0: return to IDLE with pwdata=1.
  - i_data changes mid-frame have no effect; only the captured copy is shifted.
  - ten dropping mid-frame does not abort the frame.
- RX:
  - Samples prdata once per clock and shifts LSB-first into a 12-bit register until 12 bits, including the start bit, are held.
  - Cycle after the 12th sample:
    - o_data = assembled frame;
    - rend=1, csb0=0, web0=0, addr0 = current write pointer, all for exactly one cycle;
    - the write pointer increments afterwards and wraps from 2^ADDR_W-1 to 0.
  - Then return to IDLE.
  - ren dropping mid-frame does not abort reception.
  - No parity or stop-bit checking in this block.
- Outside write cycles: csb0=1, web0=1; o_data and addr0 hold their values.
- In RX, pwdata stays 1. In TX, prdata is ignored.
- Reset asserted mid-frame: frame dropped, lines return to reset values immediately.

Decomposition:
- Package updi_phy_pkg holds:
  - FRAME_W and ADDR_W constants;
  - state enum (IDLE, TX, RX);
  - reset constants (IDLE_LINE=1'b1).
- One natural sub-module, phy_shift12: a 12-bit shift register with bit counter, shared pattern for tx (parallel-in, serial-out) and rx (serial-in, parallel-out). The top holds the FSM, the address counter and the memory strobes.

Test Plan:
- Reset: hold rst=0 with random inputs -> pwdata=1, tend=0, rend=0, csb0=1, web0=1, addr0=0, o_data=0.
- Single tx: ten=1 for one cycle, i_data=12'b110101010100 -> pwdata shows bits 0..11 LSB first on consecutive cycles, tend high only on bit 11, then pwdata=1.
- Back-to-back tx: ten held high, i_data changed every 12 cycles through 12'hC55, 12'hDAA, 12'hF00 -> 36 contiguous bits match, no idle cycle, tend pulses every 12 cycles.
- Rx: ren=1, drive prdata with frame 12'hC54 LSB first after idle-high -> one cycle later o_data=12'hC54, rend=csb0=web0 active once at addr0=0; the next frame writes at addr0=1.
- Priority and address wrap:
  - ten=1 and ren=1 with prdata=0 in IDLE -> TX taken, no rend.
  - 128 received frames -> the 129th writes at addr0=0.
- Mid-frame reset: rst=0 at bit 5 of a tx frame -> pwdata=1 immediately; after release with ten=1, a fresh frame starts from bit 0.
